// File: rtl/neogeo_reset_pkg.sv
// Shared types for the NeoGeo reset sequencer.
// Holds the state encoding and the reset cause codes.
package neogeo_reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_Z80_HOLD = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_USER = 2'd1,
        CAUSE_SYS  = 2'd2,
        CAUSE_WD   = 2'd3
    } cause_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level.
// Ports: WDCLK clock, WDRESET async reset, d async in, q synced out.
module sync2 (
    input  logic WDCLK,
    input  logic WDRESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge WDCLK or posedge WDRESET) begin
        if (WDRESET) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// NeoGeo reset sequencer: power-on, user, system and watchdog resets.
// Ports: CLK_24M, RESET (async), VBLANK, WD_KICK, WD_EN, USER_RST,
//        SYS_RST_REQ in; nRESET, nHALT, nZ80RESET, CAUSE out.
module reset_sequencer
    import neogeo_reset_pkg::*;
#(
    parameter int ASSERT_FRAMES = 8,
    parameter int WD_FRAMES     = 8,
    parameter int Z80_DELAY     = 1024
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       VBLANK,
    input  logic       WD_KICK,
    input  logic       WD_EN,
    input  logic       USER_RST,
    input  logic       SYS_RST_REQ,
    output logic       nRESET,
    output logic       nHALT,
    output logic       nZ80RESET,
    output logic [1:0] CAUSE
);

    localparam int FW = $clog2(ASSERT_FRAMES) + 1;
    localparam int WW = $clog2(WD_FRAMES) + 1;
    localparam int CW = $clog2(Z80_DELAY) + 1;

    localparam logic [FW-1:0] FRAME_END = FW'(ASSERT_FRAMES);
    localparam logic [WW-1:0] WD_END    = WW'(WD_FRAMES);
    localparam logic [CW-1:0] HOLD_END  = CW'(Z80_DELAY - 1);

    state_t        state, state_n;
    cause_t        cause, cause_n;
    logic [FW-1:0] frame_cnt, frame_cnt_n, frame_inc;
    logic [WW-1:0] wd_cnt, wd_cnt_n, wd_inc;
    logic [CW-1:0] cyc_cnt, cyc_cnt_n;
    logic          vblank_q, vblank_qq;
    logic          frame_tick;
    logic          user_sync;
    logic          wd_expire;
    logic          any_req;
    logic          nreset_q, nreset_d;
    logic          nz80_q, nz80_d;

    sync2 u_user_sync (
        .WDCLK   (CLK_24M),
        .WDRESET (RESET),
        .d       (USER_RST),
        .q       (user_sync)
    );

    assign frame_tick = vblank_q & ~vblank_qq;

    // Saturating increments: counters stick at all-ones rather than wrap.
    assign frame_inc = (frame_tick && frame_cnt != '1)
                     ? frame_cnt + FW'(1) : frame_cnt;
    assign wd_inc    = (frame_tick && wd_cnt != '1)
                     ? wd_cnt + WW'(1) : wd_cnt;

    // A kick in the same cycle as the tick wins, so no expiry then.
    assign wd_expire = (state == ST_RUN) && WD_EN && !WD_KICK
                     && frame_tick && (wd_inc == WD_END);

    assign any_req = user_sync | SYS_RST_REQ | wd_expire;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            state     <= ST_ASSERT;
            cause     <= CAUSE_POR;
            frame_cnt <= '0;
            wd_cnt    <= '0;
            cyc_cnt   <= '0;
            vblank_q  <= 1'b0;
            vblank_qq <= 1'b0;
            nreset_q  <= 1'b0;
            nz80_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cause     <= cause_n;
            frame_cnt <= frame_cnt_n;
            wd_cnt    <= wd_cnt_n;
            cyc_cnt   <= cyc_cnt_n;
            vblank_q  <= VBLANK;
            vblank_qq <= vblank_q;
            nreset_q  <= nreset_d;
            nz80_q    <= nz80_d;
        end
    end

    always_comb begin
        state_n     = state;
        cause_n     = cause;
        frame_cnt_n = frame_cnt;
        wd_cnt_n    = wd_cnt;
        cyc_cnt_n   = cyc_cnt;
        unique case (state)
            ST_ASSERT: begin
                if (user_sync) begin
                    frame_cnt_n = '0;
                end else if (SYS_RST_REQ) begin
                    frame_cnt_n = '0;
                    cause_n     = CAUSE_SYS;
                end else begin
                    frame_cnt_n = frame_inc;
                    if (frame_inc == FRAME_END) begin
                        state_n   = ST_Z80_HOLD;
                        cyc_cnt_n = '0;
                    end
                end
            end
            ST_Z80_HOLD, ST_RUN: begin
                if (any_req) begin
                    state_n     = ST_ASSERT;
                    frame_cnt_n = '0;
                    wd_cnt_n    = '0;
                    // User beats system beats watchdog.
                    if (user_sync) begin
                        cause_n = CAUSE_USER;
                    end else if (SYS_RST_REQ) begin
                        cause_n = CAUSE_SYS;
                    end else begin
                        cause_n = CAUSE_WD;
                    end
                end else if (state == ST_Z80_HOLD) begin
                    if (cyc_cnt == HOLD_END) begin
                        state_n  = ST_RUN;
                        wd_cnt_n = '0;
                    end else if (cyc_cnt != '1) begin
                        cyc_cnt_n = cyc_cnt + CW'(1);
                    end
                end else if (!WD_EN || WD_KICK) begin
                    wd_cnt_n = '0;
                end else begin
                    wd_cnt_n = wd_inc;
                end
            end
            default: begin
                state_n = ST_ASSERT;
            end
        endcase
    end

    // Outputs follow the next state so they are registered yet not late.
    always_comb begin
        nreset_d = (state_n != ST_ASSERT);
        nz80_d   = (state_n == ST_RUN);
    end

    assign nRESET    = nreset_q;
    assign nHALT     = nreset_q;
    assign nZ80RESET = nz80_q;
    assign CAUSE     = cause;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter ASSERT_FRAMES, default 8: frames nRESET/nHALT held low per reset event.
REQ-002 SHALL have parameter WD_FRAMES, default 8: unkicked frames before watchdog expiry.
REQ-003 SHALL have parameter Z80_DELAY, default 1024: CLK_24M cycles nZ80RESET stays low after nRESET release.
REQ-004 SHALL have port CLK_24M  in  1  the single system clock; all logic synchronous to its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port VBLANK  in  1  synchronous vertical-blank level; each rising edge is one frame tick.
REQ-007 SHALL have port WD_KICK  in  1  one-cycle strobe from the $300001 write decode.
REQ-008 SHALL have port WD_EN  in  1  watchdog enable level.
REQ-009 SHALL have port USER_RST  in  1  asynchronous user-button level, active-high.
REQ-010 SHALL have port SYS_RST_REQ  in  1  one-cycle strobe from the menu/OSD.
REQ-011 SHALL have port nRESET  out  1  68k/peripheral reset, active-low.
REQ-012 SHALL have port nHALT  out  1  68k halt, active-low, always equal to nRESET.
REQ-013 SHALL have port nZ80RESET  out  1  Z80 reset, active-low.
REQ-014 SHALL have port CAUSE  out  2  last reset cause: 0 power-on, 1 user, 2 system, 3 watchdog.

Function
REQ-015 SHALL synchronise USER_RST through two flip-flops before use.
REQ-016 SHALL derive FRAME_TICK as a one-cycle pulse on each 0->1 transition of registered VBLANK.
REQ-017 SHALL implement states ASSERT, Z80_HOLD, RUN.
REQ-018 In ASSERT: nRESET=0, nZ80RESET=0; frame counter increments per FRAME_TICK; at count ASSERT_FRAMES with synchronised USER_RST low, go to Z80_HOLD.
REQ-019 SHALL stay in ASSERT with frame counter held at 0 while synchronised USER_RST is high.
REQ-020 SHALL reset the ASSERT frame counter to 0 on SYS_RST_REQ received in ASSERT; CAUSE updates to 2.
REQ-021 In Z80_HOLD: nRESET=1, nZ80RESET=0; cycle counter counts to Z80_DELAY-1, then go to RUN.
REQ-022 In RUN: all reset outputs high; watchdog counter cleared on entry.
REQ-023 In RUN with WD_EN=1: watchdog counter increments per FRAME_TICK; reaching WD_FRAMES enters ASSERT with CAUSE=3.
REQ-024 WD_KICK SHALL clear the watchdog counter; WD_KICK and FRAME_TICK in the same cycle yield counter 0.
REQ-025 WD_EN=0 SHALL hold the watchdog counter at 0.
REQ-026 From Z80_HOLD or RUN: a user or system request SHALL enter ASSERT on the next clock with frame counter 0.
REQ-027 Cause priority for simultaneous requests: user > system > watchdog.
REQ-028 CAUSE SHALL change only on entry to ASSERT or per REQ-020.
REQ-029 Counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL saturate, never wrap.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 RESET high SHALL asynchronously force state ASSERT, all counters 0, nRESET=0, nHALT=0, nZ80RESET=0, CAUSE=0, synchronisers 0, VBLANK register 0.
REQ-032 Release of RESET SHALL begin a full ASSERT_FRAMES sequence with CAUSE=0.

Structure
REQ-033 State encoding and CAUSE codes SHALL live in shared package neogeo_reset_pkg.
REQ-034 The two-flop synchroniser SHALL be sub-module sync2, reused for USER_RST.
REQ-035 Watchdog counter, frame counter and cycle counter SHALL be separate registers within reset_sequencer.

Verification
REQ-036 Power-on: RESET pulse, 8 VBLANK edges -> nRESET rises after 8th edge; nZ80RESET rises 1024 cycles later; CAUSE=0.
REQ-037 Watchdog: RUN, WD_EN=1, no kicks, 8 VBLANK edges -> nRESET low next cycle, CAUSE=3, 8 more frames low.
REQ-038 Kick: kick every 7 frames for 50 frames -> nRESET never falls; kick coincident with tick -> counter 0.
REQ-039 User hold: USER_RST high 20 frames -> nRESET low throughout; release -> high after 8 further frames; CAUSE=1.
REQ-040 Collision: SYS_RST_REQ in Z80_HOLD -> ASSERT next cycle, CAUSE=2; user and watchdog same cycle -> CAUSE=1.
REQ-041 Mid-operation RESET during Z80_HOLD -> all outputs low immediately; CAUSE=0.
